// File: rtl/joint_stepper_dds.sv
// Step/direction generator for one machine joint.
// A phase accumulator turns a signed velocity command into step requests.
// A small FSM then drives the STP/DIR pins within the external driver's timing limits:
// minimum pulse width, minimum low time, and direction setup before a step.
// Optional homing load port: define JOINT_STEPPER_DDS_POS_LOAD_EN to add pos_load/pos_value.
module joint_stepper_dds #(
    parameter int unsigned FREQ_W           = 32,
    parameter int unsigned ACC_W            = 32,
    parameter int unsigned POS_W            = 32,
    parameter int unsigned PULSE_CYCLES     = 50,
    parameter int unsigned SPACE_CYCLES     = 50,
    parameter int unsigned DIR_SETUP_CYCLES = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_cmd,
    input  logic              overrun_clr,
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
    input  logic              pos_load,
    input  logic [POS_W-1:0]  pos_value,
`endif
    output logic [POS_W-1:0]  position,
    output logic              dir,
    output logic              stp,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned TMR_MAX_A = (PULSE_CYCLES > SPACE_CYCLES) ? PULSE_CYCLES : SPACE_CYCLES;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > DIR_SETUP_CYCLES) ? TMR_MAX_A : DIR_SETUP_CYCLES;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [FREQ_W-1:0] FREQ_MOST_NEG = {1'b1, {(FREQ_W-1){1'b0}}};
    localparam logic [FREQ_W-1:0] FREQ_MOST_POS = {1'b0, {(FREQ_W-1){1'b1}}};

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SPACE_LOAD = TMR_W'(SPACE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIR_SETUP  = 2'd1,
        ST_PULSE_HIGH = 2'd2,
        ST_PULSE_LOW  = 2'd3
    } state_e;

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [ACC_W-1:0]   acc_q;
    logic               step_req_q;
    logic               req_dir_q;
    logic [POS_W-1:0]   position_q;
    logic               dir_q;
    logic               stp_q;
    logic               busy_q;
    logic               overrun_q;

    logic               freq_neg_c;
    logic [FREQ_W-1:0]  freq_abs_c;
    logic [ACC_W-1:0]   mag_c;
    logic               want_dir_c;
    logic               run_c;
    logic [ACC_W:0]     acc_sum_c;
    logic               carry_c;
    logic               lost_c;
    logic               idle_req_c;
    logic               start_c;
    logic               reverse_c;
    logic [POS_W-1:0]   pos_step_c;
    logic [TMR_W-1:0]   timer_dec_c;

    // Command magnitude, accumulator sum and FSM launch conditions.
    always_comb begin
        freq_neg_c = freq_cmd[FREQ_W-1];
        freq_abs_c = freq_cmd;
        if (freq_cmd == FREQ_MOST_NEG) begin
            // Two's-complement negation would overflow back to itself.
            freq_abs_c = FREQ_MOST_POS;
        end else if (freq_neg_c) begin
            freq_abs_c = (~freq_cmd) + FREQ_W'(1);
        end
        mag_c       = ACC_W'(freq_abs_c);
        want_dir_c  = ~freq_neg_c;
        run_c       = enable && (freq_cmd != '0);
        acc_sum_c   = {1'b0, acc_q} + {1'b0, mag_c};
        carry_c     = run_c && acc_sum_c[ACC_W];
        lost_c      = carry_c && step_req_q;
        idle_req_c  = (state_q == ST_IDLE) && enable && step_req_q;
        start_c     = idle_req_c && (req_dir_q == dir_q);
        reverse_c   = idle_req_c && (req_dir_q != dir_q);
        pos_step_c  = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
        timer_dec_c = timer_q - TMR_W'(1);
    end

    // Phase accumulator and single-entry step request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            step_req_q <= 1'b0;
            req_dir_q  <= 1'b1;
        end else if (!enable) begin
            acc_q      <= '0;
            step_req_q <= 1'b0;
        end else begin
            if (run_c) begin
                acc_q <= acc_sum_c[ACC_W-1:0];
            end
            if (carry_c && !step_req_q) begin
                step_req_q <= 1'b1;
                req_dir_q  <= want_dir_c;
            end else if (start_c) begin
                step_req_q <= 1'b0;
            end
        end
    end

    // Sticky overrun flag; a new loss beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= lost_c || (overrun_q && !overrun_clr);
        end
    end

    // Pin timing FSM with position counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            position_q <= '0;
            dir_q      <= 1'b1;
            stp_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        stp_q      <= 1'b1;
                        position_q <= pos_step_c;
                        timer_q    <= PULSE_LOAD;
                        state_q    <= ST_PULSE_HIGH;
                        busy_q     <= 1'b1;
                    end else if (reverse_c) begin
                        dir_q   <= req_dir_q;
                        timer_q <= SETUP_LOAD;
                        state_q <= ST_DIR_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DIR_SETUP: begin
                    // Falls back through IDLE so the step launches one edge later.
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_dec_c;
                    end
                end
                ST_PULSE_HIGH: begin
                    if (timer_q == '0) begin
                        stp_q   <= 1'b0;
                        timer_q <= SPACE_LOAD;
                        state_q <= ST_PULSE_LOW;
                    end else begin
                        timer_q <= timer_dec_c;
                    end
                end
                ST_PULSE_LOW: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_dec_c;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    stp_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
            // Homing load overrides any step applied on the same edge.
            if (pos_load) begin
                position_q <= pos_value;
            end
`endif
        end
    end

    assign position = position_q;
    assign dir      = dir_q;
    assign stp      = stp_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_joint_stepper_dds.sv
// Bench for joint_stepper_dds: random and directed stimulus against an event-time reference model.
module tb_joint_stepper_dds;

    localparam int unsigned FREQ_W = 32;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned POS_W  = 32;
    localparam int unsigned PC     = 2;
    localparam int unsigned SC     = 2;
    localparam int unsigned DSC    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [FREQ_W-1:0] freq_cmd = '0;
    logic              overrun_clr = 1'b0;
    logic [POS_W-1:0]  position;
    logic              dir;
    logic              stp;
    logic              busy;
    logic              overrun;
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
    logic              pos_load = 1'b0;
    logic [POS_W-1:0]  pos_value = '0;
`endif

    joint_stepper_dds #(
        .FREQ_W(FREQ_W), .ACC_W(ACC_W), .POS_W(POS_W),
        .PULSE_CYCLES(PC), .SPACE_CYCLES(SC), .DIR_SETUP_CYCLES(DSC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .freq_cmd(freq_cmd),
        .overrun_clr(overrun_clr),
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
        .pos_load(pos_load),
        .pos_value(pos_value),
`endif
        .position(position),
        .dir(dir),
        .stp(stp),
        .busy(busy),
        .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pulse engine tracked as edge times rather than states.
    int          m_k;
    int          m_free_at;
    int          m_stp_low_at;
    int          m_acc;
    bit          m_req;
    bit          m_rdir;
    bit          m_dir;
    bit          m_ovr;
    logic [31:0] m_pos;
    logic        e_stp, e_dir, e_busy, e_ovr;
    logic [31:0] e_pos;

    function automatic int mag_of(input logic [31:0] f);
        longint v;
        v = longint'($signed(f));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return int'(v % (64'sd1 << ACC_W));
    endfunction

    task automatic model_expect();
        e_stp  = (m_k < m_stp_low_at);
        e_busy = (m_k < m_free_at - 1);
        e_dir  = m_dir;
        e_ovr  = m_ovr;
        e_pos  = m_pos;
    endtask

    task automatic model_reset();
        m_k = 0; m_free_at = 0; m_stp_low_at = 0; m_acc = 0;
        m_req = 0; m_rdir = 1; m_dir = 1; m_ovr = 0; m_pos = '0;
        model_expect();
    endtask

    function automatic bit model_starts_next();
        return (m_k + 1 >= m_free_at) && enable && m_req && (m_rdir == m_dir);
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int sum;
        bit carry, req_pre, started, lost;
        m_k++;
        req_pre = m_req; started = 0; carry = 0; lost = 0;
        if (m_k >= m_free_at && enable && m_req) begin
            if (m_rdir == m_dir) begin
                started      = 1;
                m_stp_low_at = m_k + PC;
                m_free_at    = m_k + PC + SC + 1;
                m_pos        = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
            end else begin
                m_dir     = m_rdir;
                m_free_at = m_k + DSC + 1;
            end
        end
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
        if (pos_load) m_pos = pos_value;
`endif
        if (enable && freq_cmd != 0) begin
            sum   = m_acc + mag_of(freq_cmd);
            carry = (sum >= (1 << ACC_W));
            m_acc = sum % (1 << ACC_W);
        end
        if (started) m_req = 0;
        if (carry) begin
            if (req_pre) lost = 1;
            else begin m_req = 1; m_rdir = !freq_cmd[31]; end
        end
        if (!enable) begin m_req = 0; m_acc = 0; end
        m_ovr = lost || (m_ovr && !overrun_clr);
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; freq_cmd = '0; overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (stp !== 1'b0) begin bad++; $display("FAIL reset_stp got=%b want=0", stp); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", dir); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", position); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int rises = 0, last_rise = 0;
        logic prev = 1'b0;
        enable = 1'b1; freq_cmd = 32'd32;
        for (int c = 1; c <= 200 && rises < 10; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL basic_cycle c=%0d got stp=%b dir=%b busy=%b ovr=%b pos=%0d want %b %b %b %b %0d",
                         c, stp, dir, busy, overrun, position, e_stp, e_dir, e_busy, e_ovr, e_pos);
            end
            if (stp && !prev) begin
                if (rises > 0) begin
                    total++;
                    if (c - last_rise != 8) begin bad++; $display("FAIL basic_period got=%0d want=8", c - last_rise); end
                end
                rises++; last_rise = c;
            end
            if (!stp && prev) begin
                total++;
                if (c - last_rise != 2) begin bad++; $display("FAIL basic_width got=%0d want=2", c - last_rise); end
            end
            prev = stp;
        end
        total++; if (rises != 10) begin bad++; $display("FAIL basic_timeout rises=%0d want=10", rises); end
        total++; if (position !== 32'd10) begin bad++; $display("FAIL basic_pos got=%0d want=10", position); end
        total++; if (dir !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL basic_dir_ovr got dir=%b ovr=%b want 1 0", dir, overrun); end
    endtask

    task automatic test_reversal();
        int dir_fall = -1, gap = -1;
        logic prev_stp, prev_dir;
        repeat (5) tick();
        prev_stp = stp; prev_dir = dir;
        freq_cmd = -32'sd32;
        for (int c = 1; c <= 120; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL rev_cycle c=%0d got stp=%b dir=%b busy=%b ovr=%b pos=%0d want %b %b %b %b %0d",
                         c, stp, dir, busy, overrun, position, e_stp, e_dir, e_busy, e_ovr, e_pos);
            end
            total++;
            if (dir !== prev_dir && (prev_stp || stp)) begin bad++; $display("FAIL rev_dir_while_stp c=%0d got dir=%b stp=%b", c, dir, stp); end
            if (prev_dir && !dir) dir_fall = c;
            if (stp && !prev_stp && dir_fall >= 0 && gap < 0) gap = c - dir_fall;
            prev_stp = stp; prev_dir = dir;
        end
        total++; if (gap != 4) begin bad++; $display("FAIL rev_setup_gap got=%0d want=4", gap); end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL rev_dir_final got=%b want=0", dir); end
    endtask

    task automatic test_overrun();
        int rises = 0, last_rise = 0, gap = 0;
        logic prev = stp;
        freq_cmd = 32'd128;
        for (int c = 1; c <= 60; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL ovr_cycle c=%0d got stp=%b dir=%b busy=%b ovr=%b pos=%0d want %b %b %b %b %0d",
                         c, stp, dir, busy, overrun, position, e_stp, e_dir, e_busy, e_ovr, e_pos);
            end
            if (stp && !prev) begin
                if (rises > 0) gap = c - last_rise;
                rises++; last_rise = c;
            end
            prev = stp;
        end
        total++; if (rises < 3 || gap != 5) begin bad++; $display("FAIL ovr_spacing got=%0d rises=%0d want=5", gap, rises); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
        freq_cmd = '0;
        repeat (10) tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
        total++; if (overrun !== e_ovr) begin bad++; $display("FAIL ovr_clear_model got=%b want=%b", overrun, e_ovr); end
        freq_cmd = 32'd128;
        repeat (12) tick();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_reset_again got=%b want=1", overrun); end
    endtask

    task automatic test_enable_drop();
        int rises = 0;
        bit seen = 0;
        logic [31:0] pos_rise;
        logic prev;
        enable = 1'b0; freq_cmd = 32'd32;
        repeat (8) tick();
        enable = 1'b1;
        prev = stp;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL endrop_pre c=%0d got stp=%b pos=%0d want %b %0d", c, stp, position, e_stp, e_pos);
            end
            if (stp && !prev) seen = 1;
            prev = stp;
        end
        total++; if (!seen) begin bad++; $display("FAIL endrop_timeout got no pulse"); end
        pos_rise = e_pos;
        tick();
        enable = 1'b0;
        prev = stp;
        for (int c = 1; c <= 25; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL endrop_post c=%0d got stp=%b busy=%b pos=%0d want %b %b %0d", c, stp, busy, position, e_stp, e_busy, e_pos);
            end
            if (stp && !prev) rises++;
            prev = stp;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL endrop_extra_pulses got=%0d want=0", rises); end
        total++; if (position !== pos_rise) begin bad++; $display("FAIL endrop_pos got=%0d want=%0d", position, pos_rise); end
    endtask

    task automatic test_saturate();
        bit seen = 0;
        enable = 1'b1; freq_cmd = 32'h8000_0000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL sat_cycle c=%0d got stp=%b dir=%b busy=%b ovr=%b pos=%0d want %b %b %b %b %0d",
                         c, stp, dir, busy, overrun, position, e_stp, e_dir, e_busy, e_ovr, e_pos);
            end
        end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL sat_dir got=%b want=0", dir); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL sat_ovr got=%b want=1", overrun); end
        for (int c = 0; c < 20 && !seen; c++) begin
            if (stp === 1'b1) seen = 1; else tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL sat_no_pulse got stp=%b", stp); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (stp !== 1'b0) begin bad++; $display("FAIL async_rst_stp got=%b want=0", stp); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL async_rst_pos got=%0d want=0", position); end
        total++; if (overrun !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL async_rst_flags got ovr=%b busy=%b want 0 0", overrun, busy); end
        enable = 1'b0; freq_cmd = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
    task automatic test_pos_load();
        bit done = 0;
        logic prev;
        enable = 1'b1; freq_cmd = 32'd32;
        for (int c = 0; c < 40 && !done; c++) begin
            if (model_starts_next()) begin
                pos_load = 1'b1; pos_value = -32'sd1000;
                tick();
                pos_load = 1'b0;
                done = 1;
                total++; if (position !== 32'hFFFF_FC18) begin bad++; $display("FAIL load_pos got=%0d want=-1000", $signed(position)); end
                total++; if (stp !== 1'b1) begin bad++; $display("FAIL load_stp got=%b want=1", stp); end
            end else begin
                tick();
            end
        end
        total++; if (!done) begin bad++; $display("FAIL load_timeout no step edge"); end
        done = 0;
        prev = stp;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (stp && !prev) done = 1;
            prev = stp;
        end
        total++; if (!done || position !== 32'hFFFF_FC19) begin bad++; $display("FAIL load_next_step got=%0d want=-999", $signed(position)); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL load_dir got=%b want=1", dir); end
    endtask
`endif

    task automatic test_random();
        int v;
        for (int c = 1; c <= 500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                v = int'($urandom_range(0, 90));
                freq_cmd = ($urandom_range(0, 1) == 1) ? 32'(-v) : 32'(v);
            end
            enable      = ($urandom_range(0, 19) != 0);
            overrun_clr = ($urandom_range(0, 9) == 0);
            tick();
            total++;
            if ({stp, dir, busy, overrun, position} !== {e_stp, e_dir, e_busy, e_ovr, e_pos}) begin
                bad++;
                $display("FAIL rand_cycle c=%0d got stp=%b dir=%b busy=%b ovr=%b pos=%0d want %b %b %b %b %0d",
                         c, stp, dir, busy, overrun, position, e_stp, e_dir, e_busy, e_ovr, e_pos);
            end
        end
        overrun_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_reversal();
        test_overrun();
        test_enable_drop();
        test_saturate();
`ifdef JOINT_STEPPER_DDS_POS_LOAD_EN
        test_pos_load();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
